npu_sched_seq: RTL and testbench

Parametrised NPU schedule sequencer, successor to the fixed 16-bit schedule buffer. It stores a microprogram of control words written through the config interface. During compute it replays the program cyclically and drives the per-cycle strobes and selects of the NPU datapath: FIFOs, PEs, accumulator and sigmoid. New capabilities are generic PE-select width, a per-entry repeat count, a stall input, an explicit program length, start/stop control, an iteration-done pulse and an error flag.

---
 rtl/npu_sched_seq.sv | 165 ++++++++++++++++
 tb/tb_npu_sched_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_sched_seq.sv
// npu_sched_seq: NPU schedule sequencer. Stores a microprogram of control
// words through the config port and, while running, replays it cyclically,
// driving the registered per-cycle strobes/selects of the NPU datapath.
// Latency: a qualifying cycle (compute=1, stall=0) shows its word on the
// outputs at the next edge. Stall or compute low freezes replay (outputs 0).
// Ports:
//   CLK, npu_rst              clock, synchronous active-high reset
//   npu_sched_write_en/din    append a control word (IDLE only, len<DEPTH)
//   npu_sched_start/stop      one-cycle run control (stop wins)
//   npu_state_compute/stall   level qualifiers for replay
//   npu_sched_* control       registered word fields for FIFOs, PEs, acc, sigmoid
//   npu_sched_busy/iter_done  RUN state / last issue of an iteration
//   npu_sched_len/err         stored entry count / sticky error
module npu_sched_seq #(
  parameter int DEPTH    = 64,
  parameter int PE_SEL_W = 3,
  parameter int REP_W    = 4,
  localparam int W       = 10 + 2*PE_SEL_W + REP_W,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                CLK,
  input  logic                npu_rst,
  input  logic                npu_sched_write_en,
  input  logic [W-1:0]        npu_sched_din,
  input  logic                npu_sched_start,
  input  logic                npu_sched_stop,
  input  logic                npu_state_compute,
  input  logic                npu_sched_stall,
  output logic                npu_sched_input_fifo_read_en,
  output logic                npu_sched_sigmoid_fifo_read_en,
  output logic                npu_sched_sigmoid_fifo_write_en,
  output logic                npu_sched_output_fifo_write_en,
  output logic [PE_SEL_W-1:0] npu_sched_pe_select_in,
  output logic                npu_sched_pe_write_en,
  output logic                npu_sched_acc_fifo_read_en,
  output logic                npu_sched_acc_fifo_write_en,
  output logic [PE_SEL_W-1:0] npu_sched_sigmoid_input_sel_pe,
  output logic                npu_sched_sigmoid_input_en,
  output logic [1:0]          npu_sched_sigmoid_function_sel,
  output logic                npu_sched_busy,
  output logic                npu_sched_iter_done,
  output logic [AW:0]         npu_sched_len,
  output logic                npu_sched_err
);

  // Control part of the word (everything below the repeat field).
  localparam int CW       = W - REP_W;
  localparam int P        = PE_SEL_W;
  localparam int O_PESEL  = 4;
  localparam int O_PEWR   = 4 + P;
  localparam int O_ACCRD  = 5 + P;
  localparam int O_ACCWR  = 6 + P;
  localparam int O_SIGSEL = 7 + P;
  localparam int O_SIGEN  = 7 + 2*P;
  localparam int O_FSEL   = 8 + 2*P;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LEN_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [0:0]       r_state;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [REP_W-1:0] r_rep_cnt;
  logic [AW:0]      r_len;
  logic             r_err;
  logic [CW-1:0]    r_ctrl;
  logic             r_iter_done;

  logic [W-1:0]     w_entry;
  logic [REP_W-1:0] w_rep;
  logic             w_qual;
  logic             w_last;
  logic             w_wr_ok;

  assign w_entry = r_mem[r_rd_ptr];
  assign w_rep   = w_entry[W-1 -: REP_W];
  assign w_qual  = (r_state == ST_RUN) && npu_state_compute && !npu_sched_stall;
  // rd_ptr is on the final stored entry of the program.
  assign w_last  = (({1'b0, r_rd_ptr} + LEN_ONE) == r_len);
  // Writes are only accepted while idle and with room left.
  assign w_wr_ok = npu_sched_write_en && (r_state == ST_IDLE) && (r_len != LEN_FULL);

  // Program storage carries no reset: contents are irrelevant until written.
  always_ff @(posedge CLK) begin
    if (w_wr_ok && !npu_rst) begin
      r_mem[r_wr_ptr] <= npu_sched_din;
    end
  end

  always_ff @(posedge CLK) begin
    if (npu_rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rep_cnt   <= '0;
      r_len       <= '0;
      r_err       <= 1'b0;
      r_ctrl      <= '0;
      r_iter_done <= 1'b0;
    end else begin
      // Outputs are pulses of the issuing cycle; zero unless re-issued.
      r_ctrl      <= '0;
      r_iter_done <= 1'b0;

      if (npu_sched_write_en) begin
        if (w_wr_ok) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
          r_len    <= r_len + LEN_ONE;
        end else begin
          r_err <= 1'b1;
        end
      end

      if (r_state == ST_IDLE) begin
        // r_len here is the pre-write length, so a same-cycle write
        // cannot enable a start on an empty program.
        if (npu_sched_start && !npu_sched_stop && (r_len != '0)) begin
          r_state   <= ST_RUN;
          r_rd_ptr  <= '0;
          r_rep_cnt <= '0;
        end
      end else begin
        if (npu_sched_stop) begin
          r_state <= ST_IDLE;
        end else if (w_qual) begin
          r_ctrl <= w_entry[CW-1:0];
          if (r_rep_cnt == w_rep) begin
            r_rep_cnt <= '0;
            if (w_last) begin
              r_rd_ptr    <= '0;
              r_iter_done <= 1'b1;
            end else begin
              r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
          end else begin
            r_rep_cnt <= r_rep_cnt + REP_ONE;
          end
        end
      end
    end
  end

  assign npu_sched_input_fifo_read_en    = r_ctrl[0];
  assign npu_sched_sigmoid_fifo_read_en  = r_ctrl[1];
  assign npu_sched_sigmoid_fifo_write_en = r_ctrl[2];
  assign npu_sched_output_fifo_write_en  = r_ctrl[3];
  assign npu_sched_pe_select_in          = r_ctrl[O_PESEL +: P];
  assign npu_sched_pe_write_en           = r_ctrl[O_PEWR];
  assign npu_sched_acc_fifo_read_en      = r_ctrl[O_ACCRD];
  assign npu_sched_acc_fifo_write_en     = r_ctrl[O_ACCWR];
  assign npu_sched_sigmoid_input_sel_pe  = r_ctrl[O_SIGSEL +: P];
  assign npu_sched_sigmoid_input_en      = r_ctrl[O_SIGEN];
  assign npu_sched_sigmoid_function_sel  = r_ctrl[O_FSEL +: 2];
  assign npu_sched_busy                  = (r_state == ST_RUN);
  assign npu_sched_iter_done             = r_iter_done;
  assign npu_sched_len                   = r_len;
  assign npu_sched_err                   = r_err;

endmodule

// File: tb/tb_npu_sched_seq.sv
// Randomised bench for npu_sched_seq with a queue-based reference model:
// the program is expanded into a flat issue list (entry index repeated
// rep+1 times) and replay simply walks that list.
module tb_npu_sched_seq;
  localparam int DEPTH = 64;
  localparam int PSW   = 3;
  localparam int REPW  = 4;
  localparam int W     = 10 + 2*PSW + REPW;
  localparam int CW    = W - REPW;
  localparam int AW    = $clog2(DEPTH);

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic          done;
    logic          busy;
    logic [AW:0]   len;
    logic          err;
  } exp_t;

  logic CLK = 1'b0;
  logic npu_rst = 1'b1;
  logic we = 1'b0, st = 1'b0, sp = 1'b0, comp = 1'b0, stl = 1'b0;
  logic [W-1:0] din = '0;

  logic in_rd, sf_rd, sf_wr, of_wr, pe_wr, acc_rd, acc_wr, sig_en, busy, done, err;
  logic [PSW-1:0] pe_sel, sig_sel;
  logic [1:0] fsel;
  logic [AW:0] len;

  always #5 CLK = ~CLK;

  npu_sched_seq #(.DEPTH(DEPTH), .PE_SEL_W(PSW), .REP_W(REPW)) dut (
    .CLK(CLK), .npu_rst(npu_rst),
    .npu_sched_write_en(we), .npu_sched_din(din),
    .npu_sched_start(st), .npu_sched_stop(sp),
    .npu_state_compute(comp), .npu_sched_stall(stl),
    .npu_sched_input_fifo_read_en(in_rd),
    .npu_sched_sigmoid_fifo_read_en(sf_rd),
    .npu_sched_sigmoid_fifo_write_en(sf_wr),
    .npu_sched_output_fifo_write_en(of_wr),
    .npu_sched_pe_select_in(pe_sel),
    .npu_sched_pe_write_en(pe_wr),
    .npu_sched_acc_fifo_read_en(acc_rd),
    .npu_sched_acc_fifo_write_en(acc_wr),
    .npu_sched_sigmoid_input_sel_pe(sig_sel),
    .npu_sched_sigmoid_input_en(sig_en),
    .npu_sched_sigmoid_function_sel(fsel),
    .npu_sched_busy(busy), .npu_sched_iter_done(done),
    .npu_sched_len(len), .npu_sched_err(err)
  );

  // Reference model state.
  logic [W-1:0] prog[$];
  int           flat[$];
  bit           running = 0;
  int           pos = 0;
  bit           m_err = 0;
  exp_t         cur = '0;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic model_step(input logic iwe, input logic [W-1:0] idin, input logic ist,
                            input logic isp, input logic icomp, input logic istl,
                            input logic irst);
    exp_t nx;
    int pre;
    logic [W-1:0] wd;
    nx = '0;
    if (irst) begin
      prog.delete(); flat.delete(); running = 0; pos = 0; m_err = 0;
    end else begin
      pre = prog.size();
      if (iwe) begin
        if (running || pre == DEPTH) m_err = 1;
        else prog.push_back(idin);
      end
      if (!running) begin
        if (ist && !isp && pre > 0) begin
          running = 1; pos = 0; flat.delete();
          foreach (prog[i]) begin
            wd = prog[i];
            for (int r = 0; r <= int'(wd[W-1 -: REPW]); r++) flat.push_back(i);
          end
        end
      end else if (isp) begin
        running = 0;
      end else if (icomp && !istl) begin
        wd = prog[flat[pos]];
        nx.ctrl = wd[CW-1:0];
        pos++;
        if (pos == flat.size()) begin
          pos = 0; nx.done = 1'b1;
        end
      end
    end
    nx.busy = running;
    nx.len  = (AW+1)'(prog.size());
    nx.err  = m_err;
    cur = nx;
  endtask

  // One clock: record what the previous edge must have produced, then
  // apply the inputs for the next edge and advance the model.
  task automatic cyc(input logic iwe, input logic [W-1:0] idin, input logic ist,
                     input logic isp, input logic icomp, input logic istl,
                     input logic irst);
    @(posedge CLK); #1;
    sb.push_back(cur);
    we = iwe; din = idin; st = ist; sp = isp; comp = icomp; stl = istl; npu_rst = irst;
    model_step(iwe, idin, ist, isp, icomp, istl, irst);
  endtask

  function automatic logic [W-1:0] rword(input int rep);
    logic [31:0] t;
    logic [W-1:0] w;
    t = $urandom;
    w = t[W-1:0];
    w[W-1 -: REPW] = REPW'(rep);
    return w;
  endfunction

  task automatic idle(input int n, input logic icomp);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, icomp, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wr(input logic [W-1:0] w);
    cyc(1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_run();
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic stop_run();
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle, so compare each negedge.
  initial begin
    exp_t e;
    logic [CW-1:0] act_ctrl;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act_ctrl = {fsel, sig_en, sig_sel, acc_wr, acc_rd, pe_wr, pe_sel,
                    of_wr, sf_wr, sf_rd, in_rd};
        chk("ctrl", 32'(act_ctrl), 32'(e.ctrl));
        chk("iter_done", 32'(done), 32'(e.done));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("len", 32'(len), 32'(e.len));
        chk("err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    logic [W-1:0] b;
    reset_dut();

    // Three rep=0 words, replay with compute held high.
    for (int i = 0; i < 3; i++) wr(rword(0));
    start_run();
    idle(12, 1'b1);
    stop_run();

    // A, B(rep=2), C with a 2-cycle stall inside B's repeats.
    reset_dut();
    wr(rword(0)); b = rword(2); wr(b); wr(rword(0));
    start_run();
    idle(2, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(10, 1'b1);
    // Write while running: dropped, err set, sequence unchanged.
    wr(rword(1));
    idle(6, 1'b1);
    // Compute low pauses replay.
    idle(3, 1'b0);
    idle(3, 1'b1);
    // Stop mid-iteration, then restart from entry 0.
    stop_run();
    idle(2, 1'b1);
    start_run();
    idle(8, 1'b1);
    // Simultaneous start and stop while running: stop wins.
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Start on an empty program is ignored; start+write on empty too.
    reset_dut();
    start_run();
    idle(2, 1'b1);
    cyc(1'b1, rword(0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    // Now len=1: start together with a write is accepted.
    cyc(1'b1, rword(1), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(8, 1'b1);
    // Reset mid-run clears everything.
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Fill to DEPTH plus one overflow write.
    reset_dut();
    for (int i = 0; i < DEPTH + 1; i++) wr(rword($urandom_range(0, 1)));
    start_run();
    for (int i = 0; i < 260; i++)
      cyc(1'b0, '0, 1'b0, 1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0), 1'b0);
    stop_run();

    // Fully random traffic.
    for (int t = 0; t < 6; t++) begin
      reset_dut();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) wr(rword($urandom_range(0, 3)));
      for (int i = 0; i < 300; i++)
        cyc(($urandom_range(0, 19) == 0), rword($urandom_range(0, 3)),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 6) != 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 199) == 0));
    end

    idle(1, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
